// File: rtl/divider_seq_pkg.sv
// Shared constants and state encoding for the sequential signed divider.
package divider_seq_pkg;

    localparam int WIDTH      = 32;
    localparam int ITER_COUNT = 32;

    localparam logic [WIDTH-1:0] INT_MIN = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        FIX,
        DONE
    } state_t;

endpackage

// File: rtl/divider_seq_nonres_step.sv
// One combinational non-restoring division step on the {remainder, quotient} accumulator.
module nonres_step
    import divider_seq_pkg::*;
(
    input  logic [2*WIDTH-1:0] acc_in,
    input  logic [WIDTH-1:0]   divisor,
    output logic [2*WIDTH-1:0] acc_out
);

    logic [2*WIDTH-1:0] shifted;
    logic [WIDTH-1:0]   upper;

    always_comb begin
        shifted = acc_in << 1;
        // Sign of the partial remainder before the shift picks add vs subtract.
        if (acc_in[2*WIDTH-1])
            upper = shifted[2*WIDTH-1:WIDTH] + divisor;
        else
            upper = shifted[2*WIDTH-1:WIDTH] - divisor;
        acc_out = {upper, shifted[WIDTH-1:1], ~upper[WIDTH-1]};
    end

endmodule

// File: rtl/divider_seq.sv
// Sequential signed 32-bit divider: magnitude non-restoring core, sign fix-up, registered results.
module divider_seq #(
    parameter int WIDTH = divider_seq_pkg::WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic [WIDTH-1:0] data_remainder,
    output logic             data_resultRDY,
    output logic             data_exception,
    output logic             busy
);

    import divider_seq_pkg::*;

    state_t             state;
    logic [4:0]         count;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   b_abs;
    logic               sign_q;
    logic               sign_r;
    logic [WIDTH-1:0]   q_pend;
    logic [WIDTH-1:0]   r_pend;
    logic               exc_pend;

    logic [WIDTH-1:0]   a_in_abs;
    logic [WIDTH-1:0]   b_in_abs;
    logic [WIDTH-1:0]   rem_fixed;

    always_comb begin
        a_in_abs  = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
        b_in_abs  = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
        rem_fixed = acc[2*WIDTH-1] ? acc[2*WIDTH-1:WIDTH] + b_abs : acc[2*WIDTH-1:WIDTH];
    end

    nonres_step u_step (
        .acc_in  (acc),
        .divisor (b_abs),
        .acc_out (acc_next)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            count          <= '0;
            acc            <= '0;
            b_abs          <= '0;
            sign_q         <= 1'b0;
            sign_r         <= 1'b0;
            q_pend         <= '0;
            r_pend         <= '0;
            exc_pend       <= 1'b0;
            data_result    <= '0;
            data_remainder <= '0;
            data_resultRDY <= 1'b0;
            data_exception <= 1'b0;
            busy           <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            data_exception <= 1'b0;

            // Publishing from DONE happens regardless of a new start, so a start
            // arriving in DONE still lets the finished pulse out.
            if (state == DONE) begin
                data_result    <= q_pend;
                data_remainder <= r_pend;
                data_exception <= exc_pend;
                data_resultRDY <= 1'b1;
                busy           <= 1'b0;
                state          <= IDLE;
            end

            if (ctrl_DIV) begin
                busy   <= 1'b1;
                count  <= '0;
                b_abs  <= b_in_abs;
                sign_q <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                sign_r <= data_operandA[WIDTH-1];
                acc    <= {{WIDTH{1'b0}}, a_in_abs};
                if (data_operandB == '0) begin
                    q_pend   <= '0;
                    r_pend   <= '0;
                    exc_pend <= 1'b1;
                    state    <= DONE;
                end else if (data_operandA == INT_MIN && data_operandB == '1) begin
                    q_pend   <= INT_MIN;
                    r_pend   <= '0;
                    exc_pend <= 1'b1;
                    state    <= DONE;
                end else begin
                    exc_pend <= 1'b0;
                    state    <= ITER;
                end
            end else begin
                case (state)
                    ITER: begin
                        acc   <= acc_next;
                        count <= count + 5'd1;
                        if (count == 5'(ITER_COUNT - 1))
                            state <= FIX;
                    end
                    FIX: begin
                        q_pend   <= sign_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
                        r_pend   <= sign_r ? -rem_fixed : rem_fixed;
                        exc_pend <= 1'b0;
                        state    <= DONE;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_divider_seq.sv
// Directed and random-pair checks for divider_seq: latency, signs, exceptions, abort, reset.
module tb_divider_seq;

    logic        clock;
    logic        reset;
    logic        ctrl_DIV;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
    logic [31:0] data_remainder;
    logic        data_resultRDY;
    logic        data_exception;
    logic        busy;

    int checks = 0;
    int errors = 0;

    divider_seq #(.WIDTH(32)) dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_remainder (data_remainder),
        .data_resultRDY (data_resultRDY),
        .data_exception (data_exception),
        .busy           (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Pulse start for one edge, then count negedges until RDY (bounded at 100).
    task automatic run_div(input logic [31:0] a, input logic [31:0] b, output int cycles);
        @(negedge clock);
        data_operandA = a;
        data_operandB = b;
        ctrl_DIV      = 1'b1;
        @(negedge clock);
        ctrl_DIV      = 1'b0;
        data_operandA = 32'hDEAD_BEEF;
        data_operandB = 32'h0000_0003;
        cycles = 1;
        while (!data_resultRDY && cycles < 100) begin
            @(negedge clock);
            cycles++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        ctrl_DIV = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        #1;
        checks++;
        if ({data_result, data_remainder, data_resultRDY, data_exception, busy} !== 67'd0) begin
            errors++;
            $display("FAIL reset_state got res=%h rem=%h rdy=%b exc=%b busy=%b want all zero",
                     data_result, data_remainder, data_resultRDY, data_exception, busy);
        end
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_basic;
        int cyc;
        run_div(32'd7, 32'd2, cyc);
        checks++;
        if (cyc !== 35) begin errors++; $display("FAIL basic_latency got %0d want 35", cyc); end
        checks++;
        if (data_result !== 32'd3 || data_remainder !== 32'd1 || data_exception !== 1'b0) begin
            errors++;
            $display("FAIL basic_7_2 got q=%h r=%h exc=%b want q=3 r=1 exc=0",
                     data_result, data_remainder, data_exception);
        end
        @(negedge clock);
        checks++;
        if (data_resultRDY !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_single_pulse got rdy=%b busy=%b want 0 0", data_resultRDY, busy);
        end
        // Outputs must hold while inputs wiggle with no start.
        data_operandA = 32'd99;
        data_operandB = 32'd9;
        repeat (5) @(negedge clock);
        checks++;
        if (data_result !== 32'd3 || data_remainder !== 32'd1 || data_resultRDY !== 1'b0) begin
            errors++;
            $display("FAIL hold got q=%h r=%h rdy=%b want 3 1 0", data_result, data_remainder, data_resultRDY);
        end
    endtask

    task automatic test_signs;
        int cyc;
        run_div(32'hFFFF_FFF9, 32'd2, cyc);
        checks++;
        if (cyc !== 35 || data_result !== 32'hFFFF_FFFD || data_remainder !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL neg7_div_2 got cyc=%0d q=%h r=%h want 35 fffffffd ffffffff",
                     cyc, data_result, data_remainder);
        end
        run_div(32'd100, 32'hFFFF_FFF9, cyc);
        checks++;
        if (data_result !== 32'hFFFF_FFF2 || data_remainder !== 32'd2) begin
            errors++;
            $display("FAIL 100_div_neg7 got q=%h r=%h want fffffff2 00000002", data_result, data_remainder);
        end
        run_div(32'hFFFF_FF9C, 32'hFFFF_FFF9, cyc);
        checks++;
        if (data_result !== 32'd14 || data_remainder !== 32'hFFFF_FFFE) begin
            errors++;
            $display("FAIL neg100_div_neg7 got q=%h r=%h want 0000000e fffffffe", data_result, data_remainder);
        end
        run_div(32'h8000_0000, 32'd2, cyc);
        checks++;
        if (data_result !== 32'hC000_0000 || data_remainder !== 32'd0 || data_exception !== 1'b0) begin
            errors++;
            $display("FAIL intmin_div_2 got q=%h r=%h exc=%b want c0000000 0 0",
                     data_result, data_remainder, data_exception);
        end
    endtask

    task automatic test_exceptions;
        int cyc;
        run_div(32'd5, 32'd0, cyc);
        checks++;
        if (cyc !== 2 || data_exception !== 1'b1 || data_result !== 32'd0 || data_remainder !== 32'd0) begin
            errors++;
            $display("FAIL div_by_zero got cyc=%0d exc=%b q=%h r=%h want 2 1 0 0",
                     cyc, data_exception, data_result, data_remainder);
        end
        @(negedge clock);
        checks++;
        if (data_exception !== 1'b0 || data_resultRDY !== 1'b0) begin
            errors++;
            $display("FAIL exc_clears got exc=%b rdy=%b want 0 0", data_exception, data_resultRDY);
        end
        run_div(32'h8000_0000, 32'hFFFF_FFFF, cyc);
        checks++;
        if (cyc !== 2 || data_exception !== 1'b1 || data_result !== 32'h8000_0000 || data_remainder !== 32'd0) begin
            errors++;
            $display("FAIL overflow got cyc=%0d exc=%b q=%h r=%h want 2 1 80000000 0",
                     cyc, data_exception, data_result, data_remainder);
        end
    endtask

    task automatic test_abort;
        int cyc;
        int pulses;
        @(negedge clock);
        data_operandA = 32'd50;
        data_operandB = 32'd5;
        ctrl_DIV = 1'b1;
        @(negedge clock);
        ctrl_DIV = 1'b0;
        repeat (10) @(negedge clock);
        run_div(32'd9, 32'd4, cyc);
        checks++;
        if (cyc !== 35 || data_result !== 32'd2 || data_remainder !== 32'd1) begin
            errors++;
            $display("FAIL abort_restart got cyc=%0d q=%h r=%h want 35 2 1", cyc, data_result, data_remainder);
        end
        pulses = 0;
        repeat (40) begin
            @(negedge clock);
            if (data_resultRDY) pulses++;
        end
        checks++;
        if (pulses !== 0) begin errors++; $display("FAIL abort_extra_pulse got %0d want 0", pulses); end
    endtask

    task automatic test_back_to_back;
        int cyc;
        // Start in DONE: the exception pulse must still appear, then the new op runs.
        @(negedge clock);
        data_operandA = 32'd5;
        data_operandB = 32'd0;
        ctrl_DIV = 1'b1;
        @(negedge clock);
        data_operandA = 32'd7;
        data_operandB = 32'd2;
        @(negedge clock);
        ctrl_DIV = 1'b0;
        checks++;
        if (data_resultRDY !== 1'b1 || data_exception !== 1'b1 || data_result !== 32'd0) begin
            errors++;
            $display("FAIL done_start_pulse got rdy=%b exc=%b q=%h want 1 1 0",
                     data_resultRDY, data_exception, data_result);
        end
        cyc = 1;
        @(negedge clock);
        while (!data_resultRDY && cyc < 100) begin
            @(negedge clock);
            cyc++;
        end
        checks++;
        if (cyc !== 34 || data_result !== 32'd3 || data_remainder !== 32'd1 || data_exception !== 1'b0) begin
            errors++;
            $display("FAIL done_start_next got cyc=%0d q=%h r=%h exc=%b want 34 3 1 0",
                     cyc, data_result, data_remainder, data_exception);
        end
    endtask

    task automatic test_reset_mid;
        int cyc;
        int pulses;
        @(negedge clock);
        data_operandA = 32'd50;
        data_operandB = 32'd5;
        ctrl_DIV = 1'b1;
        @(negedge clock);
        ctrl_DIV = 1'b0;
        repeat (20) @(negedge clock);
        reset = 1'b1;
        #1;
        checks++;
        if ({data_result, data_remainder, data_resultRDY, data_exception, busy} !== 67'd0) begin
            errors++;
            $display("FAIL reset_mid got res=%h rem=%h rdy=%b exc=%b busy=%b want all zero",
                     data_result, data_remainder, data_resultRDY, data_exception, busy);
        end
        @(negedge clock);
        reset = 1'b0;
        pulses = 0;
        repeat (30) begin
            @(negedge clock);
            if (data_resultRDY) pulses++;
        end
        checks++;
        if (pulses !== 0) begin errors++; $display("FAIL reset_no_pulse got %0d want 0", pulses); end
        run_div(32'd1, 32'd1, cyc);
        checks++;
        if (cyc !== 35 || data_result !== 32'd1 || data_remainder !== 32'd0) begin
            errors++;
            $display("FAIL after_reset got cyc=%0d q=%h r=%h want 35 1 0", cyc, data_result, data_remainder);
        end
    endtask

    task automatic test_random;
        int cyc;
        int signed a;
        int signed b;
        int signed eq;
        int signed er;
        for (int i = 0; i < 12; i++) begin
            case (i)
                0: begin a = 0;   b = -13; end
                1: begin a = 3;   b = 1000; end
                2: begin a = -5;  b = 7; end
                default: begin
                    a = $urandom;
                    b = $urandom >> ($urandom_range(0, 28));
                    if ($urandom_range(0, 1) == 1) b = -b;
                    if (b == 0 || b == 32'sh8000_0000) b = 3;
                end
            endcase
            eq = a / b;
            er = a % b;
            run_div(a, b, cyc);
            checks++;
            if (cyc !== 35 || data_result !== eq || data_remainder !== er || data_exception !== 1'b0) begin
                errors++;
                $display("FAIL random_%0d a=%h b=%h got cyc=%0d q=%h r=%h want 35 q=%h r=%h",
                         i, a, b, cyc, data_result, data_remainder, eq, er);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signs();
        test_exceptions();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/divider_seq.md
DIVIDER_SEQ -- requirements
Module: divider_seq

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width; only 32 is supported.
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 ctrl_DIV  input  1  start pulse, sampled each rising edge; captures operands.
REQ-005 data_operandA  input  WIDTH  signed two's-complement dividend, sampled only when ctrl_DIV=1.
REQ-006 data_operandB  input  WIDTH  signed two's-complement divisor, sampled only when ctrl_DIV=1.
REQ-007 data_result  output  WIDTH  signed quotient, truncated toward zero.
REQ-008 data_remainder  output  WIDTH  signed remainder, same sign as dividend or zero.
REQ-009 data_resultRDY  output  1  one-cycle pulse marking valid data_result/data_remainder/data_exception.
REQ-010 data_exception  output  1  error flag, valid only while data_resultRDY=1.
REQ-011 busy  output  1  high from the cycle after start until the cycle data_resultRDY pulses.

Function
REQ-012 States SHALL be IDLE, ITER, FIX, DONE; reset state IDLE.
REQ-013 IDLE + ctrl_DIV: latch |A|, |B|, sign_q = A[31]^B[31], sign_r = A[31]; 64-bit accumulator = {32'b0, |A|}; count = 0; go ITER.
REQ-014 ctrl_DIV with B = 0: go DONE directly, result = 0, remainder = 0, exception = 1.
REQ-015 ctrl_DIV with A = 0x80000000 and B = 0xFFFFFFFF: go DONE directly, result = 0x80000000, remainder = 0, exception = 1.
REQ-016 ITER: one non-restoring step per cycle.
  - Shift accumulator left 1.
  - Add +|B| if the upper half is negative, else add -|B|.
  - Quotient LSB = NOT(new upper-half sign).
  - count increments; after 32 steps (count == 31 at edge) go FIX.
REQ-017 FIX (one cycle): if the remainder half is negative, add |B|.
REQ-018 FIX sign correction:
  - Quotient negated when sign_q = 1.
  - Remainder negated when sign_r = 1.
  - Result and remainder registered; go DONE.
REQ-019 DONE (one cycle): data_resultRDY = 1; go IDLE next edge.
REQ-020 Latency, normal division: ctrl_DIV sampled at edge N → data_resultRDY high in cycle after edge N+34.
REQ-021 Latency, exception: data_resultRDY high in cycle after edge N+1.
REQ-022 data_result/data_remainder SHALL hold their last value until the next DONE.
REQ-023 data_exception SHALL be 0 whenever data_resultRDY = 0.
REQ-024 ctrl_DIV in ITER or FIX SHALL abort the operation and restart with newly sampled operands; no data_resultRDY is issued for the aborted operation.
REQ-025 ctrl_DIV in DONE SHALL complete the current pulse and start the new operation, as if in IDLE.
REQ-026 Operand inputs SHALL be ignored outside the ctrl_DIV edge.
REQ-027 Arithmetic SHALL be modulo 2^32 per half; |0x80000000| treated as unsigned 0x80000000.

Reset
REQ-028 reset = 1 SHALL immediately force state IDLE and count = 0, mid-operation included, with no pulse issued.
REQ-029 reset = 1 SHALL immediately force accumulator = 0, data_result = 0, data_remainder = 0, data_resultRDY = 0, data_exception = 0, busy = 0.
REQ-030 First ctrl_DIV is accepted on the first edge after reset deasserts.

Structure
REQ-031 Shared package SHALL hold WIDTH, the state encodings, ITER_COUNT = 32, and the constant INT_MIN = 0x80000000.
REQ-032 Sub-module nonres_step SHALL implement one combinational iteration: 64-bit accumulator in, |B| in, next accumulator out.
REQ-033 FSM, counter, and sign/correction logic SHALL reside in divider_seq.

Verification
REQ-034 A=7, B=2 → after 35 cycles: result 3, remainder 1, exception 0, single RDY pulse.
REQ-035 A=-7, B=2 → result -3 (0xFFFFFFFD), remainder -1; A=100, B=-7 → result -14, remainder 2.
REQ-036 A=5, B=0 → RDY 2 cycles after start, exception 1, result 0; A=0x80000000, B=-1 → exception 1, result 0x80000000.
REQ-037 Start A=50, B=5; at count=10 restart with A=9, B=4 → exactly one RDY pulse, result 2, remainder 1.
REQ-038 reset pulsed at count=20 → outputs zero immediately, no RDY pulse; next start A=1, B=1 → result 1, remainder 0.
REQ-039 Random signed pairs vs reference model (B ≠ 0), including A=0 and |A| < |B| → quotient and remainder exact.
